// File: rtl/i2s_master_tx.sv
// i2s_master_tx: clock-owning I2S transmitter. Derives BCLK/LRCK from iCLK
// and shifts 16-bit stereo samples out MSB first. Every data and LRCK change
// happens on the BCLK falling edge, so the codec samples on the rising edge.
// A one-entry valid/ready buffer holds the next {left, right} pair. It is
// moved into the shift word on the fall that starts a new frame.
module i2s_master_tx #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 3
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              en,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              oBCLK,
    output logic              oLRCK,
    output logic              oDACDAT,
    output logic              frame_start,
    output logic              underrun
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W = $clog2(2 * SLOT_W);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_W - 1);
    localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_W);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_bclk;
    logic              r_lrck;
    logic              r_dacdat;
    logic              r_frame_start;
    logic              r_underrun;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_buf_l;
    logic [DATA_W-1:0] r_buf_r;
    logic [DATA_W-1:0] r_sh_l;
    logic [DATA_W-1:0] r_sh_r;

    logic              w_tc;
    logic              w_fall;
    logic [CNT_W-1:0]  w_bit_nxt;
    logic              w_load;
    logic              w_lrck_nxt;
    logic [CNT_W-1:0]  w_pos;
    logic              w_in_data;
    logic [IDX_W-1:0]  w_idx;
    logic              w_bit_val;
    logic              w_xfer;

    assign w_tc       = (r_div_cnt == DIV_LAST);
    assign w_fall     = en && w_tc && r_bclk;
    assign w_bit_nxt  = (r_bit_cnt == CNT_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
    assign w_load     = w_fall && (w_bit_nxt == '0);
    assign w_lrck_nxt = (w_bit_nxt >= SLOT_LEN);
    // Slot position after the fall; position 0 is the I2S one-bit delay slot.
    assign w_pos      = w_lrck_nxt ? (w_bit_nxt - SLOT_LEN) : w_bit_nxt;
    assign w_in_data  = (w_pos >= CNT_W'(1)) && (w_pos <= DATA_LEN);
    assign w_idx      = IDX_W'(DATA_LEN - w_pos);
    // Position 0 (the frame load) never selects data, so the old shift word is safe here.
    assign w_bit_val  = w_lrck_nxt ? r_sh_r[w_idx] : r_sh_l[w_idx];
    assign w_xfer     = in_valid && r_in_ready;

    // BCLK divider, bit counter and serial outputs; en low parks them at reset values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_div_cnt <= '0;
            r_bit_cnt <= CNT_LAST;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b0;
            r_dacdat  <= 1'b0;
        end else if (!en) begin
            r_div_cnt <= '0;
            r_bit_cnt <= CNT_LAST;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b0;
            r_dacdat  <= 1'b0;
        end else begin
            if (w_tc) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= w_lrck_nxt;
                r_dacdat  <= w_in_data ? w_bit_val : 1'b0;
            end
        end
    end

    // Input buffer and frame load. A load sees the buffer as it was before any same-cycle transfer.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_in_ready    <= 1'b1;
            r_buf_l       <= '0;
            r_buf_r       <= '0;
            r_sh_l        <= '0;
            r_sh_r        <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load && r_in_ready;
            if (w_load) begin
                if (!r_in_ready) begin
                    r_sh_l <= r_buf_l;
                    r_sh_r <= r_buf_r;
                end else begin
                    r_sh_l <= '0;
                    r_sh_r <= '0;
                end
            end
            if (w_xfer) begin
                r_buf_l    <= l_data;
                r_buf_r    <= r_data;
                r_in_ready <= 1'b0;
            end else if (w_load && !r_in_ready) begin
                r_in_ready <= 1'b1;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign oBCLK       = r_bclk;
    assign oLRCK       = r_lrck;
    assign oDACDAT     = r_dacdat;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Bench for i2s_master_tx with a frame-timing reference model.
module tb_i2s_master_tx;

    localparam int DW    = 16;
    localparam int SW    = 32;
    localparam int BD    = 3;
    localparam int FRAME = 2 * BD * 2 * SW;

    logic          iCLK     = 1'b0;
    logic          iRST_N   = 1'b1;
    logic          en       = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] l_data   = '0;
    logic [DW-1:0] r_data   = '0;
    logic          in_ready;
    logic          oBCLK;
    logic          oLRCK;
    logic          oDACDAT;
    logic          frame_start;
    logic          underrun;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    i2s_master_tx #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(BD)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .en(en),
        .l_data(l_data), .r_data(r_data), .in_valid(in_valid), .in_ready(in_ready),
        .oBCLK(oBCLK), .oLRCK(oLRCK), .oDACDAT(oDACDAT),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: m_t counts enabled clock edges; everything else follows from it.
    int          m_t;
    logic        m_full;
    logic [31:0] m_pend;
    logic [31:0] m_word;
    logic        m_fs;
    logic        m_ur;

    function automatic bit m_load();
        return (en === 1'b1) && (((m_t + 1) % FRAME) == 2 * BD);
    endfunction

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            m_t    <= 0;
            m_full <= 1'b0;
            m_pend <= '0;
            m_word <= '0;
            m_fs   <= 1'b0;
            m_ur   <= 1'b0;
        end else begin
            m_t    <= en ? m_t + 1 : 0;
            m_fs   <= m_load();
            m_ur   <= m_load() && !m_full;
            if (m_load()) m_word <= m_full ? m_pend : 32'h0;
            m_full <= (m_full && !m_load()) || (in_valid && !m_full);
            if (in_valid && !m_full) m_pend <= {l_data, r_data};
        end
    end

    function automatic bit exp_bclk();
        return ((m_t / BD) % 2) == 1;
    endfunction

    function automatic bit exp_lrck();
        int f;
        f = m_t / (2 * BD);
        if (f == 0) return 1'b0;
        return ((f - 1) % (2 * SW)) >= SW;
    endfunction

    function automatic bit exp_dat();
        int f, pos, b;
        f = m_t / (2 * BD);
        if (f == 0) return 1'b0;
        pos = (f - 1) % (2 * SW);
        b   = pos % SW;
        if (b < 1 || b > DW) return 1'b0;
        return (pos >= SW) ? m_word[DW - b] : m_word[2 * DW - b];
    endfunction

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge iCLK);
            check("bclk", oBCLK, exp_bclk());
            check("lrck", oLRCK, exp_lrck());
            check("dacdat", oDACDAT, exp_dat());
            check("frame_start", frame_start, m_fs);
            check("underrun", underrun, m_ur);
            check("in_ready", in_ready, !m_full);
        end
    end

    // Frame decoder for the streaming phase: rebuilds each frame from rising-edge samples.
    bit          dec_on = 1'b0;
    bit          dec_have = 1'b0;
    int          ridx = 0;
    int          acc_in_frame = 0;
    logic [31:0] dec = '0;
    logic [31:0] cur_exp = '0;
    logic [31:0] exp_q[$];

    initial begin
        logic prev_bclk;
        prev_bclk = 1'b0;
        forever begin
            @(negedge iCLK);
            if (dec_on) begin
                if (frame_start) begin
                    if (dec_have) check("frame_word", dec, cur_exp);
                    check("one_accept_per_frame", acc_in_frame <= 1, 1);
                    acc_in_frame = 0;
                    if (underrun) begin
                        cur_exp = '0;
                    end else begin
                        check("queue_nonempty_on_load", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
                    end
                    dec_have = 1'b1;
                    ridx     = 0;
                    dec      = '0;
                end
                if (!prev_bclk && oBCLK) begin
                    if (ridx >= 1 && ridx <= DW) dec[2 * DW - ridx] = oDACDAT;
                    else if (ridx >= SW + 1 && ridx <= SW + DW) dec[SW + DW - ridx] = oDACDAT;
                    ridx++;
                end
            end
            prev_bclk = oBCLK;
        end
    end

    initial begin
        forever begin
            @(posedge iCLK);
            if (iRST_N && in_valid && in_ready) begin
                if (dec_on) exp_q.push_back({l_data, r_data});
                acc_in_frame++;
            end
        end
    end

    task automatic wait_fs(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(posedge iCLK); #1;
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic next_rise(output logic d, output logic lr, output int c, output bit ok);
        logic prev;
        prev = oBCLK; ok = 1'b0; d = 1'b0; lr = 1'b0; c = 0;
        for (int i = 0; i < 4 * BD + 2; i++) begin
            @(posedge iCLK); #1;
            if (!prev && oBCLK) begin
                d = oDACDAT; lr = oLRCK; c = cyc; ok = 1'b1;
                break;
            end
            prev = oBCLK;
        end
    endtask

    task automatic capture_frame(output logic [15:0] lw, output logic [15:0] rw,
                                 output int zero_errs, output int lr_errs, output int period);
        logic d, lr;
        int c, c0;
        bit ok;
        lw = '0; rw = '0; zero_errs = 0; lr_errs = 0; period = 0; c0 = 0;
        for (int r = 0; r < 2 * SW; r++) begin
            next_rise(d, lr, c, ok);
            check("bclk_rise_seen", ok, 1);
            if (!ok) break;
            if (r == 0) c0 = c;
            if (r == 1) period = c - c0;
            if (lr !== (r >= SW)) lr_errs++;
            if (r >= 1 && r <= DW) lw[DW - r] = d;
            else if (r >= SW + 1 && r <= SW + DW) rw[SW + DW - r] = d;
            else if (d !== 1'b0) zero_errs++;
        end
    endtask

    initial begin
        bit          ok, got, found;
        logic [15:0] lw, rw;
        int          ze, le, per;
        int          ur_cnt, fs_cnt, hi_cnt, nr_cnt;
        logic        prev_lr;
        int          ed_t[$];
        bit          ed_r[$];

        #1 iRST_N = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_bclk", oBCLK, 0);
        check("rst_lrck", oLRCK, 0);
        check("rst_dacdat", oDACDAT, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge iCLK) iRST_N = 1'b1;

        // First frame with a known pair
        @(negedge iCLK);
        l_data = 16'hA5C3; r_data = 16'h0F01; in_valid = 1'b1;
        @(negedge iCLK);
        in_valid = 1'b0;
        check("in_ready_after_push", in_ready, 0);
        en = 1'b1;
        wait_fs(2 * BD + 4, ok);
        check("first_frame_start_seen", ok, 1);
        check("first_frame_underrun", underrun, 0);
        capture_frame(lw, rw, ze, le, per);
        check("first_left_word", lw, 16'hA5C3);
        check("first_right_word", rw, 16'h0F01);
        check("first_frame_zero_bits", ze, 0);
        check("first_frame_lrck_bits", le, 0);
        check("bclk_period", per, 6);

        // Three empty frames
        ur_cnt = 0; fs_cnt = 0; hi_cnt = 0; nr_cnt = 0;
        prev_lr = oLRCK;
        for (int i = 0; i < 1100; i++) begin
            @(posedge iCLK); #1;
            ur_cnt += int'(underrun);
            fs_cnt += int'(frame_start);
            hi_cnt += int'(oDACDAT);
            nr_cnt += int'(!in_ready);
            if (oLRCK !== prev_lr) begin
                ed_t.push_back(cyc);
                ed_r.push_back(oLRCK);
            end
            prev_lr = oLRCK;
        end
        check("underrun_count", ur_cnt, 3);
        check("frame_start_count", fs_cnt, 3);
        check("empty_frames_dacdat_high", hi_cnt, 0);
        check("empty_frames_not_ready", nr_cnt, 0);
        check("lrck_edges_enough", ed_t.size() >= 3, 1);
        if (ed_t.size() >= 3) begin
            check("lrck_first_edge_is_fall", ed_r[0], 0);
            check("lrck_low_len", ed_t[1] - ed_t[0], 192);
            check("lrck_high_len", ed_t[2] - ed_t[1], 192);
        end

        // Randomized streaming
        acc_in_frame = 0;
        dec_on = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge iCLK);
            l_data = 16'($urandom); r_data = 16'($urandom); in_valid = 1'b1;
            got = 1'b0;
            for (int i = 0; i < FRAME + 20; i++) begin
                @(posedge iCLK);
                if (in_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            check("accept_within_frame", got, 1);
            if ($urandom_range(2) == 0) begin
                @(negedge iCLK) in_valid = 1'b0;
                repeat ($urandom_range(300)) @(negedge iCLK);
            end
        end
        @(negedge iCLK) in_valid = 1'b0;
        wait_fs(FRAME + 10, ok);
        check("drain_fs1", ok, 1);
        wait_fs(FRAME + 10, ok);
        check("drain_fs2", ok, 1);
        repeat (2) @(posedge iCLK);
        dec_on = 1'b0;

        // Transfer on the same edge as a frame load
        found = 1'b0;
        for (int i = 0; i < FRAME + 10; i++) begin
            @(negedge iCLK);
            if (m_load()) begin
                found = 1'b1;
                break;
            end
        end
        check("load_edge_found", found, 1);
        check("ready_before_same_edge", in_ready, 1);
        l_data = 16'h1234; r_data = 16'hFEDC; in_valid = 1'b1;
        @(posedge iCLK); #1;
        check("same_edge_frame_start", frame_start, 1);
        check("same_edge_underrun", underrun, 1);
        check("same_edge_in_ready", in_ready, 0);
        @(negedge iCLK) in_valid = 1'b0;
        wait_fs(FRAME + 10, ok);
        check("same_edge_next_fs", ok, 1);
        check("same_edge_next_underrun", underrun, 0);
        capture_frame(lw, rw, ze, le, per);
        check("same_edge_left", lw, 16'h1234);
        check("same_edge_right", rw, 16'hFEDC);

        // en dropped mid right slot, buffer retained
        wait_fs(2 * BD + 4, ok);
        check("pre_en_drop_fs", ok, 1);
        @(negedge iCLK);
        l_data = 16'h7E57; r_data = 16'h8001; in_valid = 1'b1;
        @(negedge iCLK) in_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge iCLK); #1;
            if (oLRCK) break;
        end
        check("reached_right_slot", oLRCK, 1);
        repeat (20) @(posedge iCLK);
        @(negedge iCLK) en = 1'b0;
        @(posedge iCLK); #1;
        check("en_off_bclk", oBCLK, 0);
        check("en_off_lrck", oLRCK, 0);
        check("en_off_dacdat", oDACDAT, 0);
        check("en_off_buffer_kept", in_ready, 0);
        repeat (50) @(negedge iCLK);
        en = 1'b1;
        wait_fs(2 * BD + 4, ok);
        check("en_on_fs", ok, 1);
        check("en_on_underrun", underrun, 0);
        capture_frame(lw, rw, ze, le, per);
        check("retained_left", lw, 16'h7E57);
        check("retained_right", rw, 16'h8001);

        // Asynchronous reset mid-word
        wait_fs(2 * BD + 4, ok);
        check("pre_reset_fs", ok, 1);
        @(negedge iCLK);
        l_data = 16'h3C3C; r_data = 16'hC3C3; in_valid = 1'b1;
        @(negedge iCLK) in_valid = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(posedge iCLK); #1;
            if (oLRCK) break;
        end
        repeat (30) @(posedge iCLK);
        #2 iRST_N = 1'b0;
        #1;
        check("arst_bclk", oBCLK, 0);
        check("arst_lrck", oLRCK, 0);
        check("arst_dacdat", oDACDAT, 0);
        check("arst_frame_start", frame_start, 0);
        check("arst_underrun", underrun, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge iCLK) iRST_N = 1'b1;
        wait_fs(2 * BD + 4, ok);
        check("post_reset_fs", ok, 1);
        check("post_reset_underrun", underrun, 1);
        repeat (5) @(posedge iCLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
